ls_usb_rx_packet: RTL and testbench
===================================

Name: ls_usb_rx_packet

Overview:
- Packet-level decoder directly downstream of the low-speed USB bit receiver in the USB host path.
- Consumes the receiver's byte stream (rdata / rdata_ready) and its EOP strobe. Validates the PID, checks CRC16 on DATA packets and counts length.
- Streams payload bytes, with the 2 CRC bytes stripped, to the host controller. Reports a one-cycle packet summary at EOP.

Parameters:
- MAX_PAYLOAD, 8, maximum accepted DATA payload bytes (low-speed limit); range 1..13.

Ports:
- clk  in  1  12 MHz system clock
- reset  in  1  synchronous, active-high reset
- rdata  in  8  received byte, LSB = first bit on wire
- rdata_ready  in  1  one-cycle strobe, rdata valid
- eop_rfe  in  1  receiver EOP indication; may be held high for more than one cycle, treated as a level
- out_data  out  8  payload byte
- out_valid  out  1  one-cycle strobe, out_data valid
- pkt_done  out  1  one-cycle strobe, summary outputs valid
- pid  out  4  low nibble of the PID byte
- pkt_len  out  4  payload byte count, excluding PID and CRC
- pid_err  out  1  PID check nibble mismatch, or PID not ACK/NAK/STALL/DATA0/DATA1
- crc_err  out  1  DATA packet CRC residual wrong
- len_err  out  1  length illegal for the PID type
- busy  out  1  high from PID byte until pkt_done

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register 0xFFFF; byte counter 0; delay line empty. Reset mid-packet aborts the packet silently: no pkt_done, no out_valid.
- EOP event = rising edge of eop_rfe (registered previous value, compare). Levels after the first cycle are ignored.
- States:
  - IDLE: waits for rdata_ready. The first byte is the PID byte. Latch pid = rdata[3:0]; pid_bad = (rdata[7:4] != ~rdata[3:0]) or PID not in {0x2, 0xA, 0xE, 0x3, 0xB}. Go to BODY; busy=1.
  - IDLE, EOP with no byte received: ignored, no pkt_done.
  - BODY, each rdata_ready:
    - byte counter++ (saturates at 15);
    - byte fed through CRC16;
    - byte pushed into a 2-entry delay line. If the line was already full, the oldest entry goes to out_data with out_valid=1 in the same cycle the register updates, i.e. 1 cycle after the rdata_ready of the 3rd and later body bytes.
    - Payload streaming only for DATA0/DATA1 with pid_bad=0 and emitted count < MAX_PAYLOAD. Excess bytes are not emitted and set overflow.
  - BODY, EOP: go to DONE.
  - DONE: one cycle; pkt_done=1 with summary outputs; then IDLE.
- Summary outputs hold their values until the next pkt_done.
- busy drops in the DONE cycle.
- CRC16 (reflected USB form), per bit b, LSB first: if (crc[0]^b) crc=(crc>>1)^0xA001 else crc>>=1. Process 8 bits per byte in one cycle (combinational unroll). crc_err = DATA PID and final crc != 0xB001.
- Lengths (n = body bytes after PID):
  - handshake: legal n = 0;
  - DATA: legal 2 <= n <= MAX_PAYLOAD+2.
  - len_err set otherwise, including overflow.
  - pkt_len = n-2 for DATA with n >= 2, else 0; saturates at 15.
- Error precedence: if pid_err=1, crc_err and len_err are forced 0.
- Simultaneous rdata_ready and EOP rising edge in BODY: byte processed first (counted, CRCed, possibly emitted); DONE next cycle uses the updated values.
- rdata_ready in DONE: treated as the PID of a new packet (enter BODY directly), no byte lost.
- Latency: out_valid 1 cycle after the causing rdata_ready; pkt_done 1 cycle after the EOP-edge cycle.

Test Plan:
- Bytes 0xD2 then EOP -> pkt_done, pid=0x2, pkt_len=0, all error flags 0, no out_valid.
- Bytes 0x4B, 0x00, 0x00 then EOP -> pid=0xB, pkt_len=0, crc_err=0, len_err=0, no out_valid.
- Bytes 0x4B, 0x00, 0x01 -> crc_err=1.
- DATA0 0xC3 + 8 payload bytes + correct CRC (computed by bench model) -> exactly 8 out_valid strobes in order, pkt_len=8, no errors.
- PID 0xC3 with 9 payload bytes + CRC -> 8 out_valid strobes, len_err=1.
- PID byte 0xC2 (check nibble bad) -> pid_err=1, crc_err=0, len_err=0, no out_valid.
- Handshake 0x5A + extra byte 0x00 -> len_err=1.
- EOP asserted 3 cycles -> single pkt_done.
- Reset asserted after 4 body bytes -> no pkt_done; a following 0xD2 packet decodes cleanly.
- rdata_ready coincident with EOP edge -> byte included in pkt_len/CRC.

Source files
------------

// File: rtl/ls_usb_rx_packet.sv
`default_nettype none
// ============================================================================
// Module   : ls_usb_rx_packet
// Purpose  : Low-speed USB packet decoder: PID check, CRC16, length, payload
//            streaming with CRC bytes stripped, one-cycle summary at EOP.
// Revision : 1.0
// ============================================================================
module ls_usb_rx_packet #(
    parameter int MAX_PAYLOAD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rdata,
    input  logic       rdata_ready,
    input  logic       eop_rfe,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       pkt_done,
    output logic [3:0] pid,
    output logic [3:0] pkt_len,
    output logic       pid_err,
    output logic       crc_err,
    output logic       len_err,
    output logic       busy
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_BODY   = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;
    localparam logic [3:0]  C_MAX_PL = 4'(MAX_PAYLOAD);
    localparam logic [3:0]  C_MAX_N  = 4'(MAX_PAYLOAD + 2);
    localparam logic [15:0] C_RESID  = 16'hB001;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    logic [1:0]  r_state, w_state_nxt;
    logic        r_eop_prev;
    logic [3:0]  r_cur_pid;
    logic        r_cur_bad;
    logic [15:0] r_crc;
    logic [3:0]  r_cnt;
    logic [7:0]  r_dl_old, r_dl_new;
    logic [1:0]  r_fill;
    logic [3:0]  r_emitted;
    logic        r_overflow;

    logic        w_eop_edge, w_body_byte, w_new_pkt, w_is_data, w_stream_en;
    logic        w_emit_slot, w_room, w_emit, w_ovf_cur, w_pid_bad_in;
    logic [15:0] w_crc_cur;
    logic [3:0]  w_cnt_cur;

    assign w_eop_edge   = eop_rfe & ~r_eop_prev;
    assign w_body_byte  = (r_state == S_BODY) && rdata_ready;
    assign w_new_pkt    = rdata_ready && (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_data    = (r_cur_pid == 4'h3) || (r_cur_pid == 4'hB);
    assign w_stream_en  = w_is_data && !r_cur_bad;
    assign w_emit_slot  = w_body_byte && (r_fill == 2'd2);
    assign w_room       = r_emitted < C_MAX_PL;
    assign w_emit       = w_emit_slot && w_stream_en && w_room;
    assign w_ovf_cur    = r_overflow | (w_emit_slot && w_stream_en && !w_room);
    assign w_crc_cur    = w_body_byte ? crc16_byte(r_crc, rdata) : r_crc;
    assign w_cnt_cur    = (w_body_byte && r_cnt != 4'hF) ? r_cnt + 4'd1 : r_cnt;
    assign w_pid_bad_in = (rdata[7:4] != ~rdata[3:0]) ||
                          !(rdata[3:0] == 4'h2 || rdata[3:0] == 4'hA || rdata[3:0] == 4'hE ||
                            rdata[3:0] == 4'h3 || rdata[3:0] == 4'hB);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (rdata_ready) w_state_nxt = S_BODY;
            S_BODY:  if (w_eop_edge)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = rdata_ready ? S_BODY : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pkt_done = (r_state == S_DONE);
        busy     = (r_state == S_BODY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_eop_prev <= 1'b0;
            r_cur_pid  <= 4'h0;
            r_cur_bad  <= 1'b0;
            r_crc      <= 16'hFFFF;
            r_cnt      <= 4'h0;
            r_dl_old   <= 8'h00;
            r_dl_new   <= 8'h00;
            r_fill     <= 2'd0;
            r_emitted  <= 4'h0;
            r_overflow <= 1'b0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            pid        <= 4'h0;
            pkt_len    <= 4'h0;
            pid_err    <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            r_eop_prev <= eop_rfe;
            out_valid  <= w_emit;
            if (w_emit) begin
                out_data  <= r_dl_old;
                r_emitted <= r_emitted + 4'd1;
            end
            if (w_new_pkt) begin
                r_cur_pid  <= rdata[3:0];
                r_cur_bad  <= w_pid_bad_in;
                r_crc      <= 16'hFFFF;
                r_cnt      <= 4'h0;
                r_fill     <= 2'd0;
                r_emitted  <= 4'h0;
                r_overflow <= 1'b0;
            end else if (w_body_byte) begin
                r_crc      <= w_crc_cur;
                r_cnt      <= w_cnt_cur;
                r_dl_old   <= r_dl_new;
                r_dl_new   <= rdata;
                r_overflow <= w_ovf_cur;
                if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
            end
            // Summary uses post-byte values so a byte coincident with EOP is counted.
            if (r_state == S_BODY && w_eop_edge) begin
                pid     <= r_cur_pid;
                pid_err <= r_cur_bad;
                crc_err <= !r_cur_bad && w_is_data && (w_crc_cur != C_RESID);
                len_err <= !r_cur_bad && (w_is_data ?
                           (w_cnt_cur < 4'd2 || w_cnt_cur > C_MAX_N || w_ovf_cur) :
                           (w_cnt_cur != 4'd0));
                pkt_len <= (w_is_data && w_cnt_cur >= 4'd2) ? w_cnt_cur - 4'd2 : 4'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ls_usb_rx_packet.sv
`default_nettype none
// ============================================================================
// Module   : tb_ls_usb_rx_packet
// Purpose  : Directed self-checking bench for ls_usb_rx_packet.
// Revision : 1.0
// ============================================================================
module tb_ls_usb_rx_packet;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rdata;
    logic       rdata_ready;
    logic       eop_rfe;
    logic [7:0] out_data;
    logic       out_valid;
    logic       pkt_done;
    logic [3:0] pid;
    logic [3:0] pkt_len;
    logic       pid_err;
    logic       crc_err;
    logic       len_err;
    logic       busy;

    int         total = 0;
    int         passed = 0;
    int         vcount = 0;
    int         done_cnt = 0;
    logic [7:0] obuf [16];
    logic [7:0] expb [16];

    ls_usb_rx_packet #(.MAX_PAYLOAD(8)) dut (
        .clk(clk), .reset(reset), .rdata(rdata), .rdata_ready(rdata_ready),
        .eop_rfe(eop_rfe), .out_data(out_data), .out_valid(out_valid),
        .pkt_done(pkt_done), .pid(pid), .pkt_len(pkt_len), .pid_err(pid_err),
        .crc_err(crc_err), .len_err(len_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            if (vcount < 16) obuf[vcount] = out_data;
            vcount++;
        end
        if (pkt_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rdata = b; rdata_ready = 1'b1;
        @(negedge clk);
        rdata_ready = 1'b0;
    endtask

    task automatic send_eop(input int n);
        eop_rfe = 1'b1;
        repeat (n) @(negedge clk);
        eop_rfe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_counts();
        vcount = 0; done_cnt = 0;
    endtask

    // PID 0xC3 plus n payload bytes and a valid CRC; the last CRC byte optionally rides the EOP edge.
    task automatic send_data(input int n, input bit last_with_eop);
        logic [15:0] c;
        logic [15:0] t;
        c = 16'hFFFF;
        send_byte(8'hC3);
        for (int i = 0; i < n; i++) begin
            expb[i] = 8'(8'h30 + i * 13);
            c = crc_upd(c, expb[i]);
            send_byte(expb[i]);
        end
        t = ~c;
        send_byte(t[7:0]);
        if (last_with_eop) begin
            rdata = t[15:8]; rdata_ready = 1'b1; eop_rfe = 1'b1;
            @(negedge clk);
            rdata_ready = 1'b0; eop_rfe = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            send_byte(t[15:8]);
            send_eop(1);
        end
    endtask

    initial begin
        reset = 1'b1; rdata = 8'h00; rdata_ready = 1'b0; eop_rfe = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_pkt_done", pkt_done, 0);
        check("rst_busy", busy, 0);
        check("rst_pid", pid, 0);
        check("rst_flags", {pkt_len, pid_err, crc_err, len_err}, 0);

        // ACK handshake
        clear_counts();
        send_byte(8'hD2);
        check("ack_busy", busy, 1);
        send_eop(1);
        check("ack_done", done_cnt, 1);
        check("ack_pid", pid, 4'h2);
        check("ack_len_flags", {pkt_len, pid_err, crc_err, len_err}, 0);
        check("ack_novalid", vcount, 0);
        check("ack_busy_low", busy, 0);

        // Empty DATA1
        clear_counts();
        send_byte(8'h4B); send_byte(8'h00); send_byte(8'h00);
        send_eop(1);
        check("d1e_pid", pid, 4'hB);
        check("d1e_len_flags", {pkt_len, pid_err, crc_err, len_err}, 0);
        check("d1e_novalid", vcount, 0);

        // Empty DATA1 with bad CRC
        clear_counts();
        send_byte(8'h4B); send_byte(8'h00); send_byte(8'h01);
        send_eop(1);
        check("d1bad_crc", crc_err, 1);
        check("d1bad_len", len_err, 0);

        // Full 8-byte DATA0
        clear_counts();
        send_data(8, 1'b0);
        check("d0_count", vcount, 8);
        for (int i = 0; i < 8; i++) check($sformatf("d0_byte%0d", i), obuf[i], expb[i]);
        check("d0_pkt_len", pkt_len, 8);
        check("d0_flags", {pid_err, crc_err, len_err}, 0);
        check("d0_pid", pid, 4'h3);

        // Oversize DATA0
        clear_counts();
        send_data(9, 1'b0);
        check("ovf_count", vcount, 8);
        check("ovf_len_err", len_err, 1);
        check("ovf_crc_err", crc_err, 0);
        check("ovf_pkt_len", pkt_len, 9);

        // Bad PID check nibble
        clear_counts();
        send_byte(8'hC2);
        send_eop(1);
        check("badpid_flags", {pid_err, crc_err, len_err}, 3'b100);
        check("badpid_novalid", vcount, 0);

        // NAK with trailing byte
        clear_counts();
        send_byte(8'h5A); send_byte(8'h00);
        send_eop(1);
        check("nak_len_err", len_err, 1);
        check("nak_pid_err", pid_err, 0);
        check("nak_pid", pid, 4'hA);

        // EOP held 3 cycles
        clear_counts();
        send_byte(8'hD2);
        send_eop(3);
        check("eop3_single_done", done_cnt, 1);

        // Reset mid-packet
        send_byte(8'hC3);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_counts();
        check("abort_busy", busy, 0);
        send_eop(1);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_valid", vcount, 0);
        send_byte(8'hD2);
        send_eop(1);
        check("post_abort_done", done_cnt, 1);
        check("post_abort_pid", pid, 4'h2);
        check("post_abort_flags", {pkt_len, pid_err, crc_err, len_err}, 0);

        // Last CRC byte coincident with EOP edge
        clear_counts();
        send_data(2, 1'b1);
        check("coinc_done", done_cnt, 1);
        check("coinc_pkt_len", pkt_len, 2);
        check("coinc_flags", {pid_err, crc_err, len_err}, 0);
        check("coinc_count", vcount, 2);
        check("coinc_byte0", obuf[0], expb[0]);
        check("coinc_byte1", obuf[1], expb[1]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
